// File: rtl/aes_round_scheduler_pkg.sv
// Shared AES-128 definitions: block type, FSM states, S-box, round constants
// and the byte-level round functions used by the round datapath.
package aes_round_scheduler_pkg;

  // Byte k of a block (column-major, k = row + 4*col) lives at element [15-k].
  typedef logic [15:0][7:0] aes_block_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} aes_state_e;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    if (rnd >= 4'd1 && rnd <= 4'd10) return RCON[rnd];
    return '0;
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] a);
    return mul2(a) ^ a;
  endfunction

  // SubBytes then ShiftRows: out(r,c) = S(in(r, (c+r) mod 4)).
  function automatic aes_block_t sub_and_shift(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        o[15 - (r + 4*c)] = SUB_BYTES_TABLE[s[15 - (r + 4*((c + r) % 4))]];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t mixcolumns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[15 - 4*c];
      a1 = s[14 - 4*c];
      a2 = s[13 - 4*c];
      a3 = s[12 - 4*c];
      o[15 - 4*c] = mul2(a0) ^ mul3(a1) ^ a2 ^ a3;
      o[14 - 4*c] = a0 ^ mul2(a1) ^ mul3(a2) ^ a3;
      o[13 - 4*c] = a0 ^ a1 ^ mul2(a2) ^ mul3(a3);
      o[12 - 4*c] = mul3(a0) ^ a1 ^ a2 ^ mul2(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One round of AES-128 key expansion: RotWord, SubWord, RCON XOR, word chain.
module aes_key_step
  import aes_round_scheduler_pkg::*;
(
  input  aes_block_t i_rkey,
  input  logic [7:0] i_rcon,
  output aes_block_t o_rkey
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_tmp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0  = i_rkey[15:12];
  assign w_w1  = i_rkey[11:8];
  assign w_w2  = i_rkey[7:4];
  assign w_w3  = i_rkey[3:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_tmp = {SUB_BYTES_TABLE[w_rot[31:24]] ^ i_rcon,
                  SUB_BYTES_TABLE[w_rot[23:16]],
                  SUB_BYTES_TABLE[w_rot[15:8]],
                  SUB_BYTES_TABLE[w_rot[7:0]]};
  assign w_n0  = w_w0 ^ w_tmp;
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign o_rkey = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_round_scheduler.sv
// Iterative AES-128 encryption controller, ROUNDS_PER_CYCLE rounds per clock.
// Optional feature macro: AES_BLOCK_CNT_EN adds the blk_cnt output-handshake counter.
module aes_round_scheduler
  import aes_round_scheduler_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES_BLOCK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  localparam int unsigned RPC = ROUNDS_PER_CYCLE;

  aes_state_e r_state, w_next;
  logic [3:0] r_rnd;
  aes_block_t r_blk, r_rkey, r_out;
  logic       w_last;

  // Unrolled round chain: stage g applies round r_rnd+g to the previous stage's output.
  for (genvar g = 0; g < RPC; g++) begin : g_round
    logic [3:0] w_rnd;
    logic [7:0] w_rcon;
    aes_block_t w_st_in, w_rk_in, w_rk_out, w_ss, w_st_out;

    if (g == 0) begin : g_first
      assign w_st_in = r_blk;
      assign w_rk_in = r_rkey;
    end else begin : g_next
      assign w_st_in = g_round[g-1].w_st_out;
      assign w_rk_in = g_round[g-1].w_rk_out;
    end

    assign w_rnd  = r_rnd + 4'(g);
    assign w_rcon = rcon_of(w_rnd);

    aes_key_step u_key_step (
      .i_rkey (w_rk_in),
      .i_rcon (w_rcon),
      .o_rkey (w_rk_out)
    );

    assign w_ss     = sub_and_shift(w_st_in);
    assign w_st_out = ((w_rnd == 4'd10) ? w_ss : mixcolumns(w_ss)) ^ w_rk_out;
  end

  assign w_last = (g_round[RPC-1].w_rnd == 4'd10);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_RUN;
      ST_RUN:  if (w_last)   w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  // Datapath: load on acceptance, advance rounds while running, latch result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd  <= '0;
      r_blk  <= '0;
      r_rkey <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_blk  <= in_data ^ in_key;
            r_rkey <= in_key;
            r_rnd  <= 4'd1;
          end
        end
        ST_RUN: begin
          r_blk  <= g_round[RPC-1].w_st_out;
          r_rkey <= g_round[RPC-1].w_rk_out;
          // Counter parks at 0 after round 10 rather than stepping past 10.
          if (w_last) begin
            r_out <= g_round[RPC-1].w_st_out;
            r_rnd <= '0;
          end else begin
            r_rnd <= r_rnd + 4'(RPC);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out;

`ifdef AES_BLOCK_CNT_EN
  logic [31:0] r_blk_cnt;

  // Count completed output handshakes, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_blk_cnt <= '0;
    else if (out_valid && out_ready) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench for aes_round_scheduler (three instances: 1, 2, 5 rounds/cycle).
module tb_aes_round_scheduler;

  logic         clk;
  logic         rst;
  logic [127:0] in_data, in_key;
  logic         iv  [3];
  logic         orr [3];
  logic         ir  [3];
  logic         ov  [3];
  logic         bz  [3];
  logic [127:0] od  [3];
  logic [31:0]  bc  [3];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  function automatic int unsigned rpc_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_scheduler #(.ROUNDS_PER_CYCLE(rpc_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .out_data  (od[g]),
      .busy      (bz[g])
`ifdef AES_BLOCK_CNT_EN
      ,
      .blk_cnt   (bc[g])
`endif
    );
  end

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- reference AES (byte arrays, GF arithmetic) ----------------
  logic [7:0] m_sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) b = {b[6:0], b[7]};
    return b;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      m_sbox[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++)
      s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row+4*col] = m_sbox[s[row + 4*((col+row)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
          s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: -1 = waiting for a block, >0 = cycles left, 0 = result offered.
  int           m_timer [3] = '{-1, -1, -1};
  logic [127:0] m_exp   [3];
  logic [127:0] m_last  [3] = '{128'h0, 128'h0, 128'h0};
  logic [31:0]  m_cnt   [3] = '{32'h0, 32'h0, 32'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_timer[i] <= -1;
        m_last[i]  <= '0;
        m_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_timer[i] < 0) begin
          if (iv[i]) begin
            m_timer[i] <= 10 / int'(rpc_of(i));
            m_exp[i]   <= aes_ref(in_data, in_key);
          end
        end else if (m_timer[i] > 0) begin
          m_timer[i] <= m_timer[i] - 1;
          if (m_timer[i] == 1) m_last[i] <= m_exp[i];
        end else if (orr[i]) begin
          m_timer[i] <= -1;
          m_cnt[i]   <= m_cnt[i] + 1;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready[%0d]", i),  128'(ir[i]), 128'(m_timer[i] < 0));
        chk($sformatf("out_valid[%0d]", i), 128'(ov[i]), 128'(m_timer[i] == 0));
        chk($sformatf("busy[%0d]", i),      128'(bz[i]), 128'(m_timer[i] >= 0));
        chk($sformatf("out_data[%0d]", i),  od[i], m_last[i]);
`ifdef AES_BLOCK_CNT_EN
        chk($sformatf("blk_cnt[%0d]", i),   128'(bc[i]), 128'(m_cnt[i]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block through instance i with optional input toggling and output backpressure.
  task automatic run_vector(input int i, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct, input bit toggle, input int hold);
    int cnt;
    in_data = pt;
    in_key  = key;
    iv[i]   = 1;
    orr[i]  = 0;
    tick();
    iv[i] = 0;
    cnt = 0;
    while (!ov[i] && cnt < 40) begin
      if (toggle) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_key  = {$urandom, $urandom, $urandom, $urandom};
        iv[i]   = 1'($urandom);
      end
      tick();
      cnt++;
    end
    iv[i] = 0;
    chk($sformatf("latency[%0d]", i), 128'(cnt), 128'(10 / int'(rpc_of(i))));
    chk($sformatf("result[%0d]", i), od[i], ct);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 128'(ov[i]), 128'd1);
      chk("hold_data", od[i], ct);
      chk("hold_ready", 128'(ir[i]), 128'd0);
    end
    orr[i] = 1;
    tick();
    orr[i] = 0;
    chk("post_hs_valid", 128'(ov[i]), 128'd0);
    chk("post_hs_ready", 128'(ir[i]), 128'd1);
  endtask

  initial begin
    int c0;
    rst = 1;
    in_data = '0;
    in_key  = '0;
    for (int i = 0; i < 3; i++) begin
      iv[i]  = 0;
      orr[i] = 0;
    end
    build_sbox();
    chk("model_sbox_00", 128'(m_sbox[0]), 128'h63);
    chk("model_sbox_53", 128'(m_sbox[8'h53]), 128'hed);
    chk("model_appB", aes_ref(B_PT, B_KEY), B_CT);
    chk("model_appC1", aes_ref(C_PT, C_KEY), C_CT);

    tick();
    tick();
    chk_en = 1;
    chk("reset_in_ready", 128'(ir[0]), 128'd1);
    chk("reset_out_valid", 128'(ov[0]), 128'd0);
    chk("reset_out_data", od[0], 128'h0);
    chk("reset_busy", 128'(bz[0]), 128'd0);
    rst = 0;
    tick();

    // App.B with inputs toggled during RUN and 20 cycles of backpressure.
    run_vector(0, B_PT, B_KEY, B_CT, 1'b1, 20);
    tick();

    // Reset with round 5 pending.
    in_data = B_PT;
    in_key  = B_KEY;
    iv[0]   = 1;
    tick();
    iv[0] = 0;
    repeat (4) tick();
    #2 rst = 1;
    #1;
    chk("midrun_busy", 128'(bz[0]), 128'd0);
    chk("midrun_out_valid", 128'(ov[0]), 128'd0);
    chk("midrun_in_ready", 128'(ir[0]), 128'd1);
    #2 rst = 0;
    tick();
    run_vector(0, C_PT, C_KEY, C_CT, 1'b0, 0);

    // App.C.1 on the 2- and 5-round-per-cycle instances.
    run_vector(1, C_PT, C_KEY, C_CT, 1'b0, 3);
    run_vector(2, C_PT, C_KEY, C_CT, 1'b0, 3);

    // Randomized traffic on instance 0, checked by the model every cycle.
    for (int n = 0; n < 400; n++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      iv[0]   = ($urandom_range(0, 2) == 0);
      orr[0]  = 1'($urandom);
      tick();
    end
    iv[0]  = 0;
    orr[0] = 1;
    repeat (15) tick();

    // Three back-to-back blocks with out_ready held high.
    c0 = m_cnt[0];
    in_data = C_PT;
    in_key  = C_KEY;
    iv[0]   = 1;
    repeat (36) tick();
    iv[0] = 0;
    chk("b2b_handshakes", 128'(m_cnt[0] - c0), 128'd3);
`ifdef AES_BLOCK_CNT_EN
    chk("b2b_blk_cnt", 128'(bc[0] - 32'(c0)), 128'd3);
`endif
    orr[0] = 0;
    repeat (3) tick();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
